// File: rtl/ysyx_23060332_mem_arb_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM states, owner IDs, mask width.
package ysyx_23060332_mem_arb_pkg;

  localparam int WMASK_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

endpackage

// File: rtl/ysyx_23060332_mem_arb_if.sv
// Bundle of the IFU, LSU and shared-memory handshakes seen by the arbiter.
interface ysyx_23060332_mem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import ysyx_23060332_mem_arb_pkg::*;

  logic               ifu_req;
  logic [ADDR_W-1:0]  ifu_addr;
  logic               ifu_gnt;
  logic               ifu_rvalid;
  logic [DATA_W-1:0]  ifu_rdata;

  logic               lsu_req;
  logic               lsu_wen;
  logic [ADDR_W-1:0]  lsu_addr;
  logic [DATA_W-1:0]  lsu_wdata;
  logic [WMASK_W-1:0] lsu_wmask;
  logic               lsu_gnt;
  logic               lsu_rvalid;
  logic [DATA_W-1:0]  lsu_rdata;

  logic               mem_valid;
  logic               mem_wen;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [WMASK_W-1:0] mem_wmask;
  logic               mem_ready;
  logic               mem_rvalid;
  logic [DATA_W-1:0]  mem_rdata;

  modport slave (
    input  ifu_req, ifu_addr,
    output ifu_gnt, ifu_rvalid, ifu_rdata,
    input  lsu_req, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    output lsu_gnt, lsu_rvalid, lsu_rdata,
    output mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport master (
    output ifu_req, ifu_addr,
    input  ifu_gnt, ifu_rvalid, ifu_rdata,
    output lsu_req, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    input  lsu_gnt, lsu_rvalid, lsu_rdata,
    input  mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    output mem_ready, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/ysyx_23060332_arb_sel.sv
// One-hot grant select: a lone requester wins; on contention the one not named by pointer wins.
module ysyx_23060332_arb_sel (
  input  logic [1:0] reqs,
  input  logic       pointer,
  output logic [1:0] grant
);

  // Index gi is the owner ID (0 = IFU, 1 = LSU); pointer names the last winner.
  for (genvar gi = 0; gi < 2; gi++) begin : g_grant
    assign grant[gi] = reqs[gi] & (~reqs[1-gi] | (pointer != 1'(gi)));
  end

endmodule

// File: rtl/ysyx_23060332_mem_arb.sv
// Two-requester (IFU/LSU) arbiter onto one memory port, one transaction in flight.
// Define YSYX_23060332_ARB_RR_EN for round-robin; otherwise LSU has fixed priority.
module ysyx_23060332_mem_arb
  import ysyx_23060332_mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  ysyx_23060332_mem_arb_if.slave         bus
);

  logic [1:0]         state_reg, state_next;
  logic               owner_reg;
  logic               wen_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [DATA_W-1:0]  wdata_reg;
  logic [WMASK_W-1:0] wmask_reg;

  logic [1:0] sel_gnt;
  logic [1:0] gnt;
  logic       arb_ptr;
  logic       in_idle, in_req, in_wait;
  logic       capture, resp;

  assign in_idle = (state_reg == ST_IDLE);
  assign in_req  = (state_reg == ST_REQ);
  assign in_wait = (state_reg == ST_WAIT);

`ifdef YSYX_23060332_ARB_RR_EN
  logic rr_ptr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg <= OWNER_IFU;
    end else if (capture) begin
      rr_ptr_reg <= gnt[1];
    end
  end

  assign arb_ptr = rr_ptr_reg;
`else
  // A pointer pinned to IFU makes the selector give LSU fixed priority.
  assign arb_ptr = OWNER_IFU;
`endif

  ysyx_23060332_arb_sel u_sel (
    .reqs    ({bus.lsu_req, bus.ifu_req}),
    .pointer (arb_ptr),
    .grant   (sel_gnt)
  );

  assign gnt     = sel_gnt & {2{in_idle}};
  assign capture = |gnt;
  assign resp    = in_wait & bus.mem_rvalid;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (capture)        state_next = ST_REQ;
      ST_REQ:  if (bus.mem_ready)  state_next = ST_WAIT;
      ST_WAIT: if (bus.mem_rvalid) state_next = ST_IDLE;
      default:                     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      owner_reg <= OWNER_IFU;
      wen_reg   <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wmask_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (capture) begin
        owner_reg <= gnt[1];
        wen_reg   <= gnt[1] & bus.lsu_wen;
        addr_reg  <= gnt[1] ? bus.lsu_addr  : bus.ifu_addr;
        wdata_reg <= gnt[1] ? bus.lsu_wdata : '0;
        wmask_reg <= gnt[1] ? bus.lsu_wmask : '0;
      end
    end
  end

  assign bus.ifu_gnt = gnt[0];
  assign bus.lsu_gnt = gnt[1];

  assign bus.mem_valid = in_req;
  assign bus.mem_wen   = in_req & wen_reg;
  assign bus.mem_addr  = in_req ? addr_reg  : '0;
  assign bus.mem_wdata = in_req ? wdata_reg : '0;
  assign bus.mem_wmask = in_req ? wmask_reg : '0;

  // Stores acknowledge through lsu_rvalid but never return data.
  assign bus.ifu_rvalid = resp & (owner_reg == OWNER_IFU);
  assign bus.lsu_rvalid = resp & (owner_reg == OWNER_LSU);
  assign bus.ifu_rdata  = bus.ifu_rvalid ? bus.mem_rdata : '0;
  assign bus.lsu_rdata  = (bus.lsu_rvalid & ~wen_reg) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_ysyx_23060332_mem_arb.sv
// Directed bench for ysyx_23060332_mem_arb; expectations follow the build's arbitration mode.
module tb_ysyx_23060332_mem_arb;

`ifdef YSYX_23060332_ARB_RR_EN
  localparam logic RR = 1'b1;
`else
  localparam logic RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  ysyx_23060332_mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ysyx_23060332_mem_arb #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%08h exp=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.ifu_req = 0; bus.ifu_addr = 0;
    bus.lsu_req = 0; bus.lsu_wen = 0; bus.lsu_addr = 0; bus.lsu_wdata = 0; bus.lsu_wmask = 0;
    bus.mem_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
    tick(); tick();
    chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_rvalids", {30'd0, bus.ifu_rvalid, bus.lsu_rvalid}, 32'd0);
    rst = 1'b0;

    // IFU alone
    tick();
    bus.ifu_req = 1; bus.ifu_addr = 32'h8000_0000; settle();
    chk("ifu_gnt_N", 32'(bus.ifu_gnt), 32'd1);
    chk("ifu_memvalid_N", 32'(bus.mem_valid), 32'd0);
    tick();
    bus.ifu_req = 0; bus.mem_ready = 1; settle();
    chk("ifu_memvalid_N1", 32'(bus.mem_valid), 32'd1);
    chk("ifu_memaddr_N1", bus.mem_addr, 32'h8000_0000);
    chk("ifu_memwen_N1", 32'(bus.mem_wen), 32'd0);
    tick();
    bus.mem_ready = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h0010_0093; settle();
    chk("ifu_rvalid_N2", 32'(bus.ifu_rvalid), 32'd1);
    chk("ifu_rdata_N2", bus.ifu_rdata, 32'h0010_0093);
    chk("ifu_lsu_rdata_N2", bus.lsu_rdata, 32'd0);
    chk("ifu_memvalid_N2", 32'(bus.mem_valid), 32'd0);
    $display("txn ifu fetch addr=80000000 rdata=%08h", bus.ifu_rdata);
    tick();
    bus.mem_rvalid = 0; settle();
    chk("ifu_rvalid_pulse", 32'(bus.ifu_rvalid), 32'd0);

    // LSU store with memory back-pressure
    bus.lsu_req = 1; bus.lsu_wen = 1; bus.lsu_addr = 32'h8000_2000;
    bus.lsu_wdata = 32'hDEAD_BEEF; bus.lsu_wmask = 8'h0F; settle();
    chk("st_gnt", 32'(bus.lsu_gnt), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) begin
        bus.lsu_req = 0; bus.lsu_wdata = 32'h1111_1111; bus.lsu_addr = 32'h0; bus.lsu_wmask = 8'hFF;
      end
      bus.mem_ready = (i == 3); settle();
      chk($sformatf("st_valid_%0d", i), 32'(bus.mem_valid), 32'd1);
      chk($sformatf("st_wen_%0d", i), 32'(bus.mem_wen), 32'd1);
      chk($sformatf("st_addr_%0d", i), bus.mem_addr, 32'h8000_2000);
      chk($sformatf("st_wdata_%0d", i), bus.mem_wdata, 32'hDEAD_BEEF);
      chk($sformatf("st_wmask_%0d", i), 32'(bus.mem_wmask), 32'h0F);
    end
    tick();
    bus.mem_ready = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h1234_5678; settle();
    chk("st_rvalid", 32'(bus.lsu_rvalid), 32'd1);
    chk("st_rdata", bus.lsu_rdata, 32'd0);
    chk("st_ifu_rvalid", 32'(bus.ifu_rvalid), 32'd0);
    $display("txn lsu store addr=80002000 wdata=deadbeef wmask=0f");
    tick();
    bus.mem_rvalid = 0; bus.lsu_wen = 0;

    // Simultaneous requests; last grant was LSU
    bus.ifu_req = 1; bus.ifu_addr = 32'h8000_0004;
    bus.lsu_req = 1; bus.lsu_addr = 32'h8000_1000; settle();
    chk("sim_ifu_gnt1", 32'(bus.ifu_gnt), 32'(RR));
    chk("sim_lsu_gnt1", 32'(bus.lsu_gnt), 32'(!RR));
    tick();
    bus.ifu_req = !RR; bus.lsu_req = RR; bus.mem_ready = 1; settle();
    chk("sim_addr1", bus.mem_addr, RR ? 32'h8000_0004 : 32'h8000_1000);
    chk("sim_no_gnt_req", {30'd0, bus.ifu_gnt, bus.lsu_gnt}, 32'd0);
    tick();
    bus.mem_ready = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'hCAFE_F00D; settle();
    chk("sim_ifu_rvalid1", 32'(bus.ifu_rvalid), 32'(RR));
    chk("sim_lsu_rvalid1", 32'(bus.lsu_rvalid), 32'(!RR));
    chk("sim_rdata1", RR ? bus.ifu_rdata : bus.lsu_rdata, 32'hCAFE_F00D);
    chk("sim_no_overlap", {30'd0, bus.ifu_gnt, bus.lsu_gnt}, 32'd0);
    $display("txn first winner=%s rdata=cafef00d", RR ? "ifu" : "lsu");
    tick();
    bus.mem_rvalid = 0; settle();
    chk("sim_ifu_gnt2", 32'(bus.ifu_gnt), 32'(!RR));
    chk("sim_lsu_gnt2", 32'(bus.lsu_gnt), 32'(RR));
    tick();
    bus.ifu_req = 0; bus.lsu_req = 0; bus.mem_ready = 1; settle();
    chk("sim_addr2", bus.mem_addr, RR ? 32'h8000_1000 : 32'h8000_0004);
    tick();
    bus.mem_ready = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h0000_0013; settle();
    chk("sim_rvalid2", {30'd0, bus.ifu_rvalid, bus.lsu_rvalid}, RR ? 32'd1 : 32'd2);
    $display("txn second winner=%s rdata=00000013", RR ? "lsu" : "ifu");
    tick();
    bus.mem_rvalid = 0;

    // Reset while waiting for the response
    bus.ifu_req = 1; bus.ifu_addr = 32'h8000_0010; settle();
    chk("rw_gnt", 32'(bus.ifu_gnt), 32'd1);
    tick();
    bus.ifu_req = 0; bus.mem_ready = 1;
    tick();
    bus.mem_ready = 0; rst = 1; settle();
    chk("rw_async_valid", 32'(bus.mem_valid), 32'd0);
    tick();
    rst = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h0000_0BAD; settle();
    chk("rw_stray_rvalid", {30'd0, bus.ifu_rvalid, bus.lsu_rvalid}, 32'd0);
    chk("rw_stray_rdata", bus.ifu_rdata, 32'd0);
    chk("rw_mem_addr", bus.mem_addr, 32'd0);
    $display("txn reset in wait, stray response dropped");
    tick();
    bus.mem_rvalid = 0; bus.ifu_req = 1; bus.ifu_addr = 32'h8000_0020; settle();
    chk("rw_regnt", 32'(bus.ifu_gnt), 32'd1);
    tick();
    bus.ifu_req = 0; bus.mem_ready = 1; settle();
    chk("rw_addr", bus.mem_addr, 32'h8000_0020);
    tick();
    bus.mem_ready = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h0000_0055; settle();
    chk("rw_rdata", bus.ifu_rdata, 32'h0000_0055);
    $display("txn ifu fetch addr=80000020 rdata=%08h", bus.ifu_rdata);
    tick();
    bus.mem_rvalid = 0;

    // Stray response while idle
    bus.mem_rvalid = 1; bus.mem_rdata = 32'hFFFF_FFFF; settle();
    chk("idle_stray_rvalid", {30'd0, bus.ifu_rvalid, bus.lsu_rvalid}, 32'd0);
    chk("idle_stray_lsu_rdata", bus.lsu_rdata, 32'd0);
    tick();
    bus.mem_rvalid = 0; bus.lsu_req = 1; bus.lsu_wen = 0; bus.lsu_addr = 32'h8000_3000; settle();
    chk("idle_stray_gnt", 32'(bus.lsu_gnt), 32'd1);
    tick();
    bus.lsu_req = 0; bus.mem_ready = 1; settle();
    chk("idle_ld_addr", bus.mem_addr, 32'h8000_3000);
    tick();
    bus.mem_ready = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'hA5A5_5A5A; settle();
    chk("idle_ld_rdata", bus.lsu_rdata, 32'hA5A5_5A5A);
    chk("idle_ld_ifu_rdata", bus.ifu_rdata, 32'd0);
    $display("txn lsu load addr=80003000 rdata=%08h", bus.lsu_rdata);
    tick();
    bus.mem_rvalid = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060332_mem_arb.md
YSYX_23060332_MEM_ARB -- requirements
Module: ysyx_23060332_mem_arb

Interface
REQ-001 Parameter: ADDR_W, 32, address width; DATA_W, 32, data width.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 ifu_req  in  1  fetch request; holds with ifu_addr stable until ifu_gnt.
REQ-005 ifu_addr  in  ADDR_W  fetch address.
REQ-006 ifu_gnt  out  1  request captured this cycle.
REQ-007 ifu_rvalid  out  1  one-cycle pulse; ifu_rdata valid.
REQ-008 ifu_rdata  out  DATA_W  fetched instruction word.
REQ-009 lsu_req  in  1  load/store request; payload stable until lsu_gnt.
REQ-010 lsu_wen  in  1  1 = store, 0 = load.
REQ-011 lsu_addr  in  ADDR_W  access address.
REQ-012 lsu_wdata  in  DATA_W  store data.
REQ-013 lsu_wmask  in  8  byte mask, same encoding as the execute unit's mem_wmask.
REQ-014 lsu_gnt  out  1  request captured this cycle.
REQ-015 lsu_rvalid  out  1  one-cycle pulse; load data, or store acknowledge.
REQ-016 lsu_rdata  out  DATA_W  load data; zero for stores.
REQ-017 mem_valid/mem_wen/mem_addr/mem_wdata/mem_wmask  out  1/1/ADDR_W/DATA_W/8  single shared memory port request.
REQ-018 mem_ready  in  1  memory accepts the request when mem_valid & mem_ready.
REQ-019 mem_rvalid/mem_rdata  in  1/DATA_W  response pulse and data; one response per accepted request.

Function
REQ-020 FSM states IDLE, REQ, WAIT; exactly one transaction outstanding at any time.
REQ-021 IDLE: when any req is high, select a winner, assert its gnt combinationally in the same cycle, latch its payload (IFU: wen=0, wmask=0, wdata=0), record the owner, and go to REQ.
REQ-022 Default arbitration: LSU has fixed priority over IFU; the loser's gnt stays 0 and its req remains pending.
REQ-023 REQ: mem_valid=1 with the latched payload; mem_* stays stable until mem_ready; on mem_ready go to WAIT.
REQ-024 WAIT: mem_valid=0; on mem_rvalid, pulse the owner's rvalid and drive rdata=mem_rdata (combinational pass-through), then go to IDLE.
REQ-025 Latency: req at cycle N gives gnt at N, mem_valid at N+1, and earliest rvalid at N+2 (mem_ready at N+1, mem_rvalid at N+2).
REQ-026 The next grant is possible no earlier than the cycle after rvalid; no back-to-back overlap.
REQ-027 mem_rvalid in IDLE or REQ is ignored; no rvalid is produced.
REQ-028 A requester dropping req before gnt is legal; nothing is captured for it.
REQ-029 The non-owner's rvalid is always 0, and its rdata is 0.
REQ-030 Outside REQ, mem_valid=0 and mem_wen/mem_addr/mem_wdata/mem_wmask=0.

Reset
REQ-031 rst asserted: state=IDLE, owner=IFU, all outputs 0, latched payload 0, RR pointer = IFU.
REQ-032 Reset mid-transaction abandons it without an rvalid; a later stray mem_rvalid is ignored per REQ-027.

Configuration
REQ-033 YSYX_23060332_ARB_RR_EN defined: round-robin arbitration; on simultaneous requests, the requester not granted last wins; the pointer updates on each gnt.
REQ-034 YSYX_23060332_ARB_RR_EN undefined: fixed LSU priority per REQ-022; no pointer register.

Structure
REQ-035 The FSM state encoding, the owner encoding (IFU=0, LSU=1) and the wmask widths belong in the shared define file.
REQ-036 The grant-selection logic is one sub-module, ysyx_23060332_arb_sel (inputs: reqs, pointer; output: one-hot grant).

Verification
REQ-037 IFU alone: ifu_addr=0x80000000, mem_ready=1 immediately, mem_rvalid one cycle later with rdata=0x00100093 -> gnt at N, mem_valid at N+1, ifu_rvalid at N+2 with rdata=0x00100093.
REQ-038 Simultaneous requests, fixed priority: LSU load @0x80001000 wins; IFU is granted in the cycle after lsu_rvalid.
REQ-039 Same stimulus with RR_EN and last grant LSU -> IFU wins first, then LSU.
REQ-040 Store: wdata=0xDEADBEEF, wmask=0x0F, mem_ready held low for 3 cycles -> mem_* stable for 4 cycles, then lsu_rvalid with lsu_rdata=0.
REQ-041 rst asserted in WAIT, then mem_rvalid=1 -> no rvalid, all outputs 0, next request granted normally.
REQ-042 Stray mem_rvalid in IDLE -> no rvalid on either side; state stays IDLE.
